// File: rtl/gray_pkg.sv
// Shared constants, operation encoding and Gray/binary conversion helpers
// for the Gray up/down counter slice.
package gray_pkg;

  localparam int unsigned GRAY_WIDTH_DEFAULT = 4;
  localparam int unsigned GRAY_WIDTH_MAX     = 16;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_STEP,
    OP_LOAD,
    OP_CLR
  } cnt_op_e;

  function automatic logic [GRAY_WIDTH_MAX-1:0] bin2gray(input logic [GRAY_WIDTH_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // MSB passes straight through; each lower bit folds in the decoded bit above it.
  function automatic logic [GRAY_WIDTH_MAX-1:0] gray2bin(input logic [GRAY_WIDTH_MAX-1:0] g);
    logic [GRAY_WIDTH_MAX-1:0] b;
    b[GRAY_WIDTH_MAX-1] = g[GRAY_WIDTH_MAX-1];
    for (int unsigned i = 1; i < GRAY_WIDTH_MAX; i++) begin
      b[GRAY_WIDTH_MAX-1-i] = b[GRAY_WIDTH_MAX-i] ^ g[GRAY_WIDTH_MAX-1-i];
    end
    return b;
  endfunction

endpackage

// File: rtl/binary_to_graycode_converter.sv
// Purely combinational binary-to-Gray encoder; inverse of
// graycode_to_binary_converter.
module binary_to_graycode_converter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] binary,
  output logic [WIDTH-1:0] graycode
);

  // g[W-1] = b[W-1]; g[i] = b[i+1] ^ b[i]
  assign graycode = binary ^ (binary >> 1);

endmodule

// File: rtl/gray_up_down_counter.sv
// Up/down counter with registered binary and Gray outputs and a wrap pulse.
// Optional synchronous parallel load is built when GRAY_CNT_LOAD_EN is defined.
module gray_up_down_counter
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = GRAY_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
`ifdef GRAY_CNT_LOAD_EN
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
`endif
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] binary,
  output logic             wrap
);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;
  logic             load_req;
  logic [WIDTH-1:0] load_val;
  cnt_op_e          op;

`ifdef GRAY_CNT_LOAD_EN
  assign load_req = load;
  assign load_val = load_bin;
`else
  assign load_req = 1'b0;
  assign load_val = '0;
`endif

  always_comb begin
    op = OP_HOLD;
    if (clr)           op = OP_CLR;
    else if (load_req) op = OP_LOAD;
    else if (en)       op = OP_STEP;
  end

  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    unique case (op)
      OP_CLR:  bin_d = '0;
      OP_LOAD: bin_d = load_val;
      OP_STEP: begin
        if (up) begin
          bin_d  = bin_q + WIDTH'(1);
          wrap_d = &bin_q;
        end else begin
          bin_d  = bin_q - WIDTH'(1);
          wrap_d = ~|bin_q;
        end
      end
      default: ;
    endcase
  end

  // Gray is encoded from the next binary value so both registers load together.
  binary_to_graycode_converter #(
    .WIDTH(WIDTH)
  ) u_b2g (
    .binary  (bin_d),
    .graycode(gray_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign binary = bin_q;
  assign gray   = gray_q;
  assign wrap   = wrap_q;

endmodule

// File: tb/tb_gray_up_down_counter.sv
// Directed scoreboard bench for gray_up_down_counter at WIDTH=4;
// load checks are built only when GRAY_CNT_LOAD_EN is defined.
module tb_gray_up_down_counter;

  logic       clk = 1'b0;
  logic       rst_n, en, up, clr, load;
  logic [3:0] load_bin;
  logic [3:0] gray, binary;
  logic       wrap;

  int n_total = 0;
  int n_bad   = 0;

`ifdef GRAY_CNT_LOAD_EN
  localparam bit LOAD_ON = 1'b1;
`else
  localparam bit LOAD_ON = 1'b0;
`endif

  typedef struct {
    logic [3:0] b;
    logic [3:0] g;
    logic       w;
    bit         stepped;
    string      tag;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] mb;

  logic [3:0] up_tbl [16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101,
                              4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010,
                              4'b1011, 4'b1001, 4'b1000, 4'b0000};

  gray_up_down_counter #(
    .WIDTH(4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .up      (up),
    .clr     (clr),
`ifdef GRAY_CNT_LOAD_EN
    .load    (load),
    .load_bin(load_bin),
`endif
    .gray    (gray),
    .binary  (binary),
    .wrap    (wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [3:0] enc(input logic [3:0] b);
    logic [3:0] g;
    g[3] = b[3];
    for (int i = 0; i < 3; i++) g[i] = b[i+1] ^ b[i];
    return g;
  endfunction

  function automatic logic [3:0] dec(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic c, input logic l, input logic [3:0] lb,
                      input logic e, input logic u, input string tag);
    exp_t       x;
    logic [3:0] nb;
    logic       w;
    logic [3:0] pg;
    clr = c; load = l; load_bin = lb; en = e; up = u;
    nb = mb;
    w  = 1'b0;
    x.stepped = 1'b0;
    if (c) nb = 4'h0;
    else if (LOAD_ON && l) nb = lb;
    else if (e) begin
      x.stepped = 1'b1;
      if (u) begin nb = mb + 4'd1; w = (mb == 4'hF); end
      else   begin nb = mb - 4'd1; w = (mb == 4'h0); end
    end
    x.b = nb; x.g = enc(nb); x.w = w; x.tag = tag;
    sb.push_back(x);
    mb = nb;
    pg = gray;
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk({x.tag, "_bin"},  16'(binary), 16'(x.b));
    chk({x.tag, "_gray"}, 16'(gray),   16'(x.g));
    chk({x.tag, "_wrap"}, 16'(wrap),   16'(x.w));
    chk({x.tag, "_g2b"},  16'(dec(gray)), 16'(binary));
    if (x.stepped) chk({x.tag, "_onebit"}, 16'($countones(gray ^ pg)), 16'd1);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; up = 1'b0; clr = 1'b0; load = 1'b0; load_bin = 4'h0;
    mb = 4'h0;
    #1;
    chk("rst_bin",  16'(binary), 16'h0);
    chk("rst_gray", 16'(gray),   16'h0);
    chk("rst_wrap", 16'(wrap),   16'h0);
    #11 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, "up16");
      chk("up16_tbl",  16'(gray), 16'(up_tbl[i]));
      chk("up16_wrap_only_last", 16'(wrap), (i == 15) ? 16'd1 : 16'd0);
    end

    step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, "down_wrap");
    chk("down_wrap_bin_c",  16'(binary), 16'hF);
    chk("down_wrap_gray_c", 16'(gray),   16'h8);
    chk("down_wrap_w_c",    16'(wrap),   16'h1);
    step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, "down2");
    chk("down2_bin_c",  16'(binary), 16'hE);
    chk("down2_gray_c", 16'(gray),   16'h9);
    chk("down2_w_c",    16'(wrap),   16'h0);

    step(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, "dir_up_a");
    step(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, "dir_up_b");
    step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, "dir_dn_a");
    step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, "dir_dn_b");
    step(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, "dir_up_c");
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, "hold_a");
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, "hold_b");

    for (int i = 0; i < 24; i++)
      step(1'b0, 1'b0, 4'h0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");

`ifdef GRAY_CNT_LOAD_EN
    step(1'b0, 1'b1, 4'hA, 1'b1, 1'b1, "load_en");
    chk("load_bin_c",  16'(binary), 16'hA);
    chk("load_gray_c", 16'(gray),   16'hF);
    step(1'b0, 1'b1, 4'h3, 1'b0, 1'b0, "load_only");
`endif

    step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, "clr");
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, "to7");
    chk("at7_bin", 16'(binary), 16'h7);
    step(1'b1, 1'b1, 4'h3, 1'b1, 1'b1, "clr_all");
    chk("clr_all_bin_c",  16'(binary), 16'h0);
    chk("clr_all_gray_c", 16'(gray),   16'h0);
    chk("clr_all_wrap_c", 16'(wrap),   16'h0);

    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, "to5");
    chk("at5_bin", 16'(binary), 16'h5);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_gray", 16'(gray),   16'h0);
    chk("async_rst_bin",  16'(binary), 16'h0);
    chk("async_rst_wrap", 16'(wrap),   16'h0);
    mb = 4'h0;
    #2 rst_n = 1'b1;
    step(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, "post_rst");
    chk("post_rst_gray_c", 16'(gray), 16'h1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
